// File: rtl/pulse_event_sequencer.sv
// pulse_event_sequencer: queues one-cycle upstream events and sequences a
// start/busy/done handshake with a user core for each queued event.
// Optional RUN watchdog is compiled in when PULSE_SEQ_TIMEOUT_EN is defined;
// without it RUN waits indefinitely and o_timeout is tied low.
module pulse_event_sequencer #(
  parameter int unsigned CNT_W          = 3,
  parameter int unsigned BUSY_WAIT      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_pulse,
  output logic             o_ready,
  output logic             o_start,
  input  logic             i_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pending,
  output logic             o_overflow,
  input  logic             i_clr_overflow,
  output logic             o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam int unsigned      WAIT_W    = $clog2(BUSY_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_pending;
  logic [WAIT_W-1:0] r_wait;
  logic              r_overflow;
  logic              w_dec;
  logic              w_full;
  logic              w_accept;
  logic              w_drop;
  logic              w_tmo_hit;

  // A pulse at full capacity is still taken when a start frees a slot in the same cycle.
  assign w_dec    = (r_state == S_START);
  assign w_full   = (r_pending == CNT_MAX);
  assign w_accept = i_pulse && (!w_full || w_dec);
  assign w_drop   = i_pulse && w_full && !w_dec;

  assign o_ready    = !w_full;
  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;

  // Pending event counter: increment on accept, decrement when leaving START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else if (w_accept && !w_dec) begin
      r_pending <= r_pending + 1'b1;
    end else if (!w_accept && w_dec) begin
      r_pending <= r_pending - 1'b1;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Cycles spent in WAIT_BUSY; held at zero in every other state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait <= '0;
    end else if (r_state != S_WAIT_BUSY) begin
      r_wait <= '0;
    end else begin
      r_wait <= r_wait + 1'b1;
    end
  end

`ifdef PULSE_SEQ_TIMEOUT_EN
  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo;
  logic             r_timeout;

  // RUN watchdog: counts cycles in RUN, zero on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo <= '0;
    end else if (r_state != S_RUN) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_tmo_hit = (r_state == S_RUN) && i_busy && (r_tmo == TMO_LAST);

  // Sticky timeout flag; a watchdog hit in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout <= 1'b0;
    end else if (w_tmo_hit) begin
      r_timeout <= 1'b1;
    end else if (i_clr_overflow) begin
      r_timeout <= 1'b0;
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused_tmo_cfg;
  assign w_unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign w_tmo_hit        = 1'b0;
  assign o_timeout        = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (r_pending != '0) w_next = S_START;
      S_START:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (i_busy) begin
          w_next = S_RUN;
        end else if (r_wait == WAIT_LAST) begin
          w_next = S_DONE;
        end
      end
      S_RUN:       if (!i_busy || w_tmo_hit) w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // FSM outputs: single-cycle strobes decoded from state.
  always_comb begin
    o_start = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      S_START: o_start = 1'b1;
      S_DONE:  o_done  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pulse_event_sequencer.sv
// Self-checking bench for pulse_event_sequencer. Expected start/done strobes
// are queued by each scenario and consumed by a negedge monitor.
module tb_pulse_event_sequencer;

  localparam int CNT_W = 3;
  localparam int BW    = 4;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             i_pulse = 1'b0;
  logic             i_busy = 1'b0;
  logic             i_clr_overflow = 1'b0;
  logic             o_ready;
  logic             o_start;
  logic             o_done;
  logic [CNT_W-1:0] o_pending;
  logic             o_overflow;
  logic             o_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_mode = 0;   // 0: low, 1: high 5 cycles from each start, 2: stuck high
  int busy_cnt = 0;
  int n_start = 0;
  int n_done = 0;
  int exp_start[$];
  int exp_done[$];
  int e_s;
  int e_d;

  pulse_event_sequencer #(
    .CNT_W(CNT_W),
    .BUSY_WAIT(BW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_pulse(i_pulse),
    .o_ready(o_ready),
    .o_start(o_start),
    .i_busy(i_busy),
    .o_done(o_done),
    .o_pending(o_pending),
    .o_overflow(o_overflow),
    .i_clr_overflow(i_clr_overflow),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // User core model.
  always @(negedge clk) begin
    case (busy_mode)
      1: begin
        if (o_start) busy_cnt = 5;
        if (busy_cnt > 0) begin
          i_busy = 1'b1;
          busy_cnt--;
        end else begin
          i_busy = 1'b0;
        end
      end
      2:       i_busy = 1'b1;
      default: i_busy = 1'b0;
    endcase
  end

  // Scoreboard monitor: every strobe must match a queued expectation.
  always @(negedge clk) begin
    if (o_start) begin
      n_start++;
      checks++;
      if (exp_start.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected: o_start=1 at cycle %0d, required no start", cyc);
      end else begin
        e_s = exp_start.pop_front();
        if (e_s >= 0 && e_s != cyc) begin
          errors++;
          $display("FAIL start_cycle: got cycle %0d, expected cycle %0d", cyc, e_s);
        end
      end
    end
    if (o_done) begin
      n_done++;
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: o_done=1 at cycle %0d, required no done", cyc);
      end else begin
        e_d = exp_done.pop_front();
        if (e_d >= 0 && e_d != cyc) begin
          errors++;
          $display("FAIL done_cycle: got cycle %0d, expected cycle %0d", cyc, e_d);
        end
      end
    end
  end

  task automatic wait_drain(input int bound);
    int k = 0;
    while ((exp_start.size() != 0 || exp_done.size() != 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_start.size() != 0 || exp_done.size() != 0) begin
      errors++;
      $display("FAIL drain: outstanding starts=%0d dones=%0d, expected 0 and 0",
               exp_start.size(), exp_done.size());
    end
    exp_start.delete();
    exp_done.delete();
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks += 6;
    if (o_pending !== 3'd0) begin errors++; $display("FAIL rst_pending: got %0d, expected 0", o_pending); end
    if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, expected 1", o_ready); end
    if (o_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b, expected 0", o_start); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, expected 0", o_done); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b, expected 0", o_overflow); end
    if (o_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b, expected 0", o_timeout); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    int s0;
    int d0;
    busy_mode = 1;
    repeat (2) @(negedge clk);
    s0 = n_start;
    d0 = n_done;
    n = cyc;
    i_pulse = 1'b1;
    exp_start.push_back(n + 2);
    exp_done.push_back(n + 8);
    @(negedge clk);
    i_pulse = 1'b0;
    checks++;
    if (o_pending !== 3'd1) begin errors++; $display("FAIL single_pend1: got %0d, expected 1", o_pending); end
    repeat (2) @(negedge clk);
    checks++;
    if (o_pending !== 3'd0) begin errors++; $display("FAIL single_pend0: got %0d, expected 0", o_pending); end
    wait_drain(40);
    checks++;
    if (n_start - s0 != 1 || n_done - d0 != 1) begin
      errors++;
      $display("FAIL single_counts: got starts=%0d dones=%0d, expected 1 and 1", n_start - s0, n_done - d0);
    end
  endtask

  task automatic test_zero_len();
    int n;
    busy_mode = 0;
    repeat (2) @(negedge clk);
    n = cyc;
    i_pulse = 1'b1;
    exp_start.push_back(n + 2);
    exp_done.push_back(n + 3 + BW);
    @(negedge clk);
    i_pulse = 1'b0;
    wait_drain(30);
    checks++;
    if (o_timeout !== 1'b0) begin errors++; $display("FAIL zero_len_timeout: got %b, expected 0", o_timeout); end
  endtask

  task automatic test_back_to_back();
    int n;
    busy_mode = 0;
    repeat (2) @(negedge clk);
    n = cyc;
    i_pulse = 1'b1;
    exp_start.push_back(n + 2);
    exp_done.push_back(n + 7);
    exp_start.push_back(n + 9);
    exp_done.push_back(n + 14);
    repeat (2) @(negedge clk);
    i_pulse = 1'b0;
    wait_drain(60);
  endtask

  task automatic test_overflow();
    int peak = 0;
    int s0;
    busy_mode = 2;
    repeat (2) @(negedge clk);
    s0 = n_start;
    for (int i = 0; i < 8; i++) begin
      exp_start.push_back(-1);
      exp_done.push_back(-1);
    end
    for (int i = 0; i < 9; i++) begin
      if (int'(o_pending) > peak) peak = int'(o_pending);
      if (i == 8) begin
        checks++;
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b, expected 0", o_overflow); end
      end
      i_pulse = 1'b1;
      @(negedge clk);
    end
    i_pulse = 1'b0;
    if (int'(o_pending) > peak) peak = int'(o_pending);
    checks += 4;
    if (peak != 7) begin errors++; $display("FAIL ovf_peak: got %0d, expected 7", peak); end
    if (o_pending !== 3'd7) begin errors++; $display("FAIL ovf_pending: got %0d, expected 7", o_pending); end
    if (o_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b, expected 0", o_ready); end
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, expected 1", o_overflow); end
    i_pulse = 1'b1;
    i_clr_overflow = 1'b1;
    @(negedge clk);
    i_pulse = 1'b0;
    i_clr_overflow = 1'b0;
    checks += 2;
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b, expected 1", o_overflow); end
    if (o_pending !== 3'd7) begin errors++; $display("FAIL ovf_no_wrap: got %0d, expected 7", o_pending); end
    i_clr_overflow = 1'b1;
    @(negedge clk);
    i_clr_overflow = 1'b0;
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, expected 0", o_overflow); end
    busy_mode = 0;
    wait_drain(150);
    checks++;
    if (n_start - s0 != 8) begin errors++; $display("FAIL ovf_starts: got %0d, expected 8", n_start - s0); end
  endtask

  task automatic test_coincident();
    int k = 0;
    busy_mode = 2;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      exp_start.push_back(-1);
      exp_done.push_back(-1);
    end
    for (int i = 0; i < 8; i++) begin
      i_pulse = 1'b1;
      @(negedge clk);
    end
    i_pulse = 1'b0;
    checks += 2;
    if (o_pending !== 3'd7) begin errors++; $display("FAIL coin_fill: got %0d, expected 7", o_pending); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL coin_fill_ovf: got %b, expected 0", o_overflow); end
    busy_mode = 0;
    while (o_start !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (o_start !== 1'b1) begin
      errors++;
      $display("FAIL coin_start_wait: got no start in %0d cycles, expected a start", k);
    end else begin
      i_pulse = 1'b1;
      @(negedge clk);
      i_pulse = 1'b0;
      checks += 2;
      if (o_pending !== 3'd7) begin errors++; $display("FAIL coin_pending: got %0d, expected 7", o_pending); end
      if (o_overflow !== 1'b0) begin errors++; $display("FAIL coin_ovf: got %b, expected 0", o_overflow); end
    end
    wait_drain(200);
  endtask

  task automatic test_timeout();
    int n;
    int d0;
    busy_mode = 2;
    repeat (2) @(negedge clk);
    n = cyc;
    d0 = n_done;
    i_pulse = 1'b1;
    exp_start.push_back(n + 2);
`ifdef PULSE_SEQ_TIMEOUT_EN
    exp_done.push_back(n + 4 + TMO);
    @(negedge clk);
    i_pulse = 1'b0;
    wait_drain(50);
    checks += 2;
    if (o_timeout !== 1'b1) begin errors++; $display("FAIL tmo_set: got %b, expected 1", o_timeout); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL tmo_ovf: got %b, expected 0", o_overflow); end
    i_clr_overflow = 1'b1;
    @(negedge clk);
    i_clr_overflow = 1'b0;
    checks++;
    if (o_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b, expected 0", o_timeout); end
    busy_mode = 0;
`else
    @(negedge clk);
    i_pulse = 1'b0;
    repeat (40) @(negedge clk);
    checks += 2;
    if (o_timeout !== 1'b0) begin errors++; $display("FAIL tmo_off_flag: got %b, expected 0", o_timeout); end
    if (n_done != d0) begin errors++; $display("FAIL tmo_off_done: got %0d dones, expected 0", n_done - d0); end
    exp_done.push_back(-1);
    busy_mode = 0;
    wait_drain(20);
`endif
  endtask

  task automatic test_reset_mid_run();
    int s0;
    int d0;
    busy_mode = 2;
    repeat (2) @(negedge clk);
    exp_start.push_back(cyc + 2);
    i_pulse = 1'b1;
    repeat (4) @(negedge clk);
    i_pulse = 1'b0;
    @(negedge clk);
    checks++;
    if (o_pending !== 3'd3) begin errors++; $display("FAIL rrun_pending: got %0d, expected 3", o_pending); end
    #2 reset_n = 1'b0;
    #1;
    exp_start.delete();
    exp_done.delete();
    checks += 6;
    if (o_pending !== 3'd0) begin errors++; $display("FAIL rrun_pend0: got %0d, expected 0", o_pending); end
    if (o_ready !== 1'b1) begin errors++; $display("FAIL rrun_ready: got %b, expected 1", o_ready); end
    if (o_start !== 1'b0) begin errors++; $display("FAIL rrun_start: got %b, expected 0", o_start); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL rrun_done: got %b, expected 0", o_done); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL rrun_ovf: got %b, expected 0", o_overflow); end
    if (o_timeout !== 1'b0) begin errors++; $display("FAIL rrun_tmo: got %b, expected 0", o_timeout); end
    s0 = n_start;
    d0 = n_done;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    busy_mode = 0;
    repeat (30) @(negedge clk);
    checks += 2;
    if (n_start != s0 || n_done != d0) begin
      errors++;
      $display("FAIL rrun_quiet: got starts=%0d dones=%0d, expected 0 and 0", n_start - s0, n_done - d0);
    end
    if (o_pending !== 3'd0) begin errors++; $display("FAIL rrun_after: got %0d, expected 0", o_pending); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_len();
    test_back_to_back();
    test_overflow();
    test_coincident();
    test_timeout();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_event_sequencer.md
PULSE_EVENT_SEQUENCER -- requirements
Module: pulse_event_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 3, width of pending-event counter (capacity 2^CNT_W-1 = 7).
REQ-002 SHALL have parameter BUSY_WAIT, default 4, cycles allowed after o_start for i_busy to rise.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, RUN watchdog limit (used only per REQ-030).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 i_pulse  input  1  one-cycle event from upstream CDC pulse receiver.
REQ-007 o_ready  output  1  event capacity available; drives upstream receiver ready.
REQ-008 o_start  output  1  one-cycle start strobe to user core.
REQ-009 i_busy  input  1  user core busy level.
REQ-010 o_done  output  1  one-cycle completion strobe, suitable for a return CDC pulse sender.
REQ-011 o_pending  output  CNT_W  queued events not yet started.
REQ-012 o_overflow  output  1  sticky: event received while full.
REQ-013 i_clr_overflow  input  1  clears o_overflow and o_timeout.
REQ-014 o_timeout  output  1  sticky watchdog flag.

Function
REQ-015 Pending counter: +1 on accepted i_pulse, -1 on cycle leaving START; both same cycle -> unchanged.
REQ-016 o_ready SHALL equal (o_pending != 2^CNT_W-1), combinational from counter register.
REQ-017 i_pulse with o_pending at max and no same-cycle decrement SHALL be dropped and set o_overflow next cycle; counter never wraps.
REQ-018 i_pulse at max coinciding with decrement SHALL be accepted (count stays max), no overflow.
REQ-019 FSM states: IDLE, START, WAIT_BUSY, RUN, DONE.
REQ-020 IDLE -> START when o_pending != 0; else stay.
REQ-021 START: o_start=1 for exactly one cycle; -> WAIT_BUSY; decrement pending.
REQ-022 WAIT_BUSY: i_busy=1 -> RUN; after BUSY_WAIT cycles with i_busy=0 -> DONE (zero-length operation).
REQ-023 RUN: i_busy=0 -> DONE.
REQ-024 DONE: o_done=1 for exactly one cycle; -> IDLE.
REQ-025 Latency: pulse in cycle N with FSM idle and count 0 -> o_start in cycle N+2.
REQ-026 Back-to-back queued events: minimum 1 IDLE cycle between DONE and next START.
REQ-027 i_clr_overflow SHALL clear sticky flags next cycle; a simultaneous set event SHALL win over clear.

Reset
REQ-028 reset_n low SHALL immediately force: FSM IDLE, o_pending 0, o_start 0, o_done 0, o_overflow 0, o_timeout 0, wait/watchdog counters 0; o_ready=1.
REQ-029 Reset mid-RUN SHALL discard queued events and SHALL NOT emit o_done; release resumes from IDLE with empty queue.

Configuration
REQ-030 Macro PULSE_SEQ_TIMEOUT_EN defined: RUN counts cycles; at TIMEOUT_CYCLES with i_busy still 1 -> DONE, set o_timeout, o_done still pulses; counter cleared on entering RUN.
REQ-031 Macro undefined: RUN waits indefinitely, no watchdog logic, o_timeout tied 0, port list unchanged.

Verification
REQ-032 Single pulse, i_busy high 5 cycles after start -> o_start once at N+2, o_done once, o_pending 1->0.
REQ-033 Nine pulses back-to-back with i_busy held 1 -> o_pending peaks 7, o_ready 0 at 7, o_overflow=1; exactly 8 starts total once busy released per op.
REQ-034 Pulse coincident with START decrement at count 7 -> count stays 7, o_overflow stays 0.
REQ-035 Start with i_busy never asserted, BUSY_WAIT=4 -> o_done 4 cycles after WAIT_BUSY entry, o_timeout 0.
REQ-036 With PULSE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, i_busy stuck 1 -> DONE after 16 RUN cycles, o_timeout=1, cleared by i_clr_overflow.
REQ-037 reset_n asserted in RUN with 3 pending -> all outputs reset instantly, no o_done, no start after release.
